// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit pair per clock, LSD first, with a registered inter-digit carry.
// Optional invalid-digit flag built only when BCD_INVALID_DIGIT_CHECK_EN is defined.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sum_shift;
  logic [3:0]          cnt_q, cnt_d;
  logic                c_q, c_d, cout_q, cout_d;
  logic [3:0]          ad, bd, digit;
  logic [4:0]          s;
  logic                gt9, last, accept;

  assign ad     = a_q[3:0];
  assign bd     = b_q[3:0];
  assign s      = {1'b0, ad} + {1'b0, bd} + {4'b0, c_q};
  assign gt9    = s > 5'd9;
  assign digit  = gt9 ? s[3:0] + 4'd6 : s[3:0];
  assign last   = cnt_q == 4'(DIGITS - 1);
  assign accept = start && (state_q != ADD);

  // New digits enter at the MSB end so the LSD ends up in [3:0].
  generate
    if (DIGITS == 1) begin : g_one
      assign sum_shift = digit;
    end else begin : g_many
      assign sum_shift = {digit, sum_q[4*DIGITS-1:4]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last)  state_d = DONE;
      DONE:    state_d = start ? ADD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ADD);
    done = (state_q == DONE);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    if (accept) begin
      a_d    = a;
      b_d    = b;
      c_d    = cin;
      cnt_d  = '0;
      sum_d  = '0;
      cout_d = 1'b0;
    end else if (state_q == ADD) begin
      a_d   = a_q >> 4;
      b_d   = b_q >> 4;
      c_d   = gt9;
      cnt_d = cnt_q + 4'd1;
      sum_d = sum_shift;
      if (last) cout_d = gt9;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef BCD_INVALID_DIGIT_CHECK_EN
  logic err_q, err_d;

  // Sticky across the whole operation; cleared only by an accepted start.
  always_comb begin
    err_d = err_q;
    if (accept)                err_d = 1'b0;
    else if (state_q == ADD)   err_d = err_q | (ad > 4'd9) | (bd > 4'd9);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: driver queues expected results, monitor checks on done.
module tb_bcd_serial_adder;
  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

`ifdef BCD_INVALID_DIGIT_CHECK_EN
  localparam logic ERR_ON_BAD = 1'b1;
`else
  localparam logic ERR_ON_BAD = 1'b0;
`endif

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum",      32'(sum),  32'(e.sum));
        chk("cout",     32'(cout), 32'(e.cout));
        chk("err",      32'(err),  32'(e.err));
        chk("done_cyc", 32'(cyc),  32'(e.cyc));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input bit push, input logic [W-1:0] es, input logic ec, input logic ee);
    exp_t e;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    if (push) begin
      e.sum = es; e.cout = ec; e.err = ee; e.cyc = cyc + 1 + DIGITS;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs: the latched operands must be unaffected.
    a = '1; b = '1; cin = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(16'h1234, 16'h5678, 1'b0, 1, 16'h6912, 1'b0, 1'b0); drain();
    issue(16'h9999, 16'h0001, 1'b0, 1, 16'h0000, 1'b1, 1'b0); drain();
    issue(16'h0000, 16'h0000, 1'b1, 1, 16'h0001, 1'b0, 1'b0); drain();

    // Start re-pulsed mid-operation must be ignored.
    issue(16'h0005, 16'h0005, 1'b0, 1, 16'h0010, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Async reset mid-ADD: sum already holds a partial digit before reset.
    issue(16'h1234, 16'h5678, 1'b0, 0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sum",  32'(sum),  32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(16'h0999, 16'h0001, 1'b0, 1, 16'h1000, 1'b0, 1'b0); drain();

    // Back-to-back: start asserted during DONE of the first op.
    begin
      exp_t e;
      int n = 0;
      issue(16'h1234, 16'h5678, 1'b0, 1, 16'h6912, 1'b0, 1'b0);
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_first_done", 32'(done), 32'd1);
      a = 16'h0050; b = 16'h0050; cin = 1'b0; start = 1'b1;
      e.sum = 16'h0100; e.cout = 1'b0; e.err = 1'b0; e.cyc = cyc + 1 + DIGITS;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      drain();
    end

    issue(16'h00A0, 16'h0000, 1'b0, 1, 16'h0100, 1'b0, ERR_ON_BAD); drain();
    issue(16'h0011, 16'h0022, 1'b0, 1, 16'h0033, 1'b0, 1'b0);       drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
